// File: rtl/trivium_lite_core_if.sv
// Tile-side bus bundle for trivium_lite_core: data byte in/out, command/seed
// byte and the bidirectional-pin controls. The tile only ever listens on uio.
interface trivium_lite_core_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Driver side (board / bench)
  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  // Cipher tile side
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/trivium_lite_core.sv
// trivium_lite_core: byte-wide reduced-state Trivium-style stream cipher.
// One keystream bit per clock is shifted into an 8-bit window; the output
// byte is ui_in XOR that window, so encrypt and decrypt are the same
// operation given the same seed and cycle timing.
// uio_in command: 8'h00 run, 8'hFF clear, anything else loads a seed.
// Optional feature macro TRIVIUM_WARMUP_EN: after each seed load the first
// WARMUP_CYCLES steps advance A/B/C without shifting the keystream window.
module trivium_lite_core #(
  parameter int WARMUP_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  trivium_lite_core_if.slave bus
);
  localparam logic [7:0]  CMD_RUN   = 8'h00;
  localparam logic [7:0]  CMD_CLEAR = 8'hFF;
  localparam logic [43:0] B_INIT    = 44'h5A5A5A5A5A5;
  localparam logic [47:0] C_INIT    = 48'h7;

  logic [39:0] a_reg, a_next;
  logic [43:0] b_reg, b_next;
  logic [47:0] c_reg, c_next;
  logic [7:0]  ks_reg, ks_next;
  logic        run_reg, run_next;

  logic        t1, t2, t3, z, n1, n2, n3;
  logic [39:0] seed_rep;

`ifdef TRIVIUM_WARMUP_EN
  localparam int             CW         = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CW-1:0]  WARM_LIMIT = CW'(WARMUP_CYCLES);
  logic [CW-1:0] warm_reg, warm_next;
`else
  logic unused_warmup;
  assign unused_warmup = (WARMUP_CYCLES > 0);
`endif

  // Tile enable is deliberately ignored: the cipher is always active.
  logic unused_ena;
  assign unused_ena = bus.ena;

  // Seed byte replicated across the 40-bit A register.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_seed_rep
      assign seed_rep[gi*8 +: 8] = bus.uio_in;
    end
  endgenerate

  // Feedback taps and keystream bit, all taken from the current state.
  always_comb begin
    t1 = a_reg[27] ^ a_reg[39];
    t2 = b_reg[29] ^ b_reg[43];
    t3 = c_reg[35] ^ c_reg[47];
    z  = t1 ^ t2 ^ t3;
    n1 = t1 ^ (a_reg[37] & a_reg[38]) ^ b_reg[40];
    n2 = t2 ^ (b_reg[41] & b_reg[42]) ^ c_reg[44];
    n3 = t3 ^ (c_reg[45] & c_reg[46]) ^ a_reg[30];
  end

  // Command decode: clear, (re)load while a seed is presented, else step when running.
  always_comb begin
    a_next   = a_reg;
    b_next   = b_reg;
    c_next   = c_reg;
    ks_next  = ks_reg;
    run_next = run_reg;
`ifdef TRIVIUM_WARMUP_EN
    warm_next = warm_reg;
`endif
    if (bus.uio_in == CMD_CLEAR) begin
      a_next   = '0;
      b_next   = '0;
      c_next   = '0;
      ks_next  = '0;
      run_next = 1'b0;
`ifdef TRIVIUM_WARMUP_EN
      warm_next = '0;
`endif
    end else if (bus.uio_in != CMD_RUN) begin
      a_next   = seed_rep;
      b_next   = B_INIT;
      c_next   = C_INIT;
      ks_next  = '0;
      run_next = 1'b1;
`ifdef TRIVIUM_WARMUP_EN
      warm_next = '0;
`endif
    end else if (run_reg) begin
      a_next = {a_reg[38:0], n3};
      b_next = {b_reg[42:0], n1};
      c_next = {c_reg[46:0], n2};
`ifdef TRIVIUM_WARMUP_EN
      if (warm_reg < WARM_LIMIT) begin
        warm_next = warm_reg + 1'b1;
      end else begin
        ks_next = {ks_reg[6:0], z};
      end
`else
      ks_next = {ks_reg[6:0], z};
`endif
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      c_reg   <= '0;
      ks_reg  <= '0;
      run_reg <= 1'b0;
`ifdef TRIVIUM_WARMUP_EN
      warm_reg <= '0;
`endif
    end else begin
      a_reg   <= a_next;
      b_reg   <= b_next;
      c_reg   <= c_next;
      ks_reg  <= ks_next;
      run_reg <= run_next;
`ifdef TRIVIUM_WARMUP_EN
      warm_reg <= warm_next;
`endif
    end
  end

  // Zero-latency data path: each output bit is the input bit XOR its keystream bit.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_out_xor
      assign bus.uo_out[gi] = bus.ui_in[gi] ^ ks_reg[gi];
    end
  endgenerate

  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_trivium_lite_core.sv
// Testbench for trivium_lite_core: directed round-trip / clear / reset cases
// plus randomized command traffic, checked every cycle against a bit-queue
// reference model of the cipher.
module tb_trivium_lite_core;
  logic clk;
  logic rst_n;

  trivium_lite_core_if bus();

  trivium_lite_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: registers as bit queues, index i == bit i, index 0 newest.
  bit         qa[$];
  bit         qb[$];
  bit         qc[$];
  logic [7:0] m_ks;
  bit         m_run;
  int         m_warm;
  localparam int M_WARMUP = 64;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    qa.delete(); qb.delete(); qc.delete();
    for (int i = 0; i < 40; i++) qa.push_back(1'b0);
    for (int i = 0; i < 44; i++) qb.push_back(1'b0);
    for (int i = 0; i < 48; i++) qc.push_back(1'b0);
    m_ks = 8'h00; m_run = 1'b0; m_warm = 0;
  endtask

  task automatic model_load(input logic [7:0] s);
    logic [43:0] binit;
    binit = 44'h5A5A5A5A5A5;
    for (int i = 0; i < 40; i++) qa[i] = s[i % 8];
    for (int i = 0; i < 44; i++) qb[i] = binit[i];
    for (int i = 0; i < 48; i++) qc[i] = (i < 3);
    m_ks = 8'h00; m_run = 1'b1; m_warm = 0;
  endtask

  task automatic model_step();
    bit t1, t2, t3, z, n1, n2, n3;
    t1 = qa[27] ^ qa[39];
    t2 = qb[29] ^ qb[43];
    t3 = qc[35] ^ qc[47];
    z  = t1 ^ t2 ^ t3;
    n1 = t1 ^ (qa[37] & qa[38]) ^ qb[40];
    n2 = t2 ^ (qb[41] & qb[42]) ^ qc[44];
    n3 = t3 ^ (qc[45] & qc[46]) ^ qa[30];
    qa.push_front(n3); void'(qa.pop_back());
    qb.push_front(n1); void'(qb.pop_back());
    qc.push_front(n2); void'(qc.pop_back());
`ifdef TRIVIUM_WARMUP_EN
    if (m_warm < M_WARMUP) m_warm++;
    else m_ks = {m_ks[6:0], z};
`else
    m_ks = {m_ks[6:0], z};
`endif
  endtask

  task automatic model_apply(input logic [7:0] cmd);
    if (cmd == 8'hFF)      model_clear();
    else if (cmd != 8'h00) model_load(cmd);
    else if (m_run)        model_step();
  endtask

  // One clock: drive on the falling edge, check the output, then let the edge happen.
  task automatic do_cycle(input logic [7:0] cmd, input logic [7:0] data,
                          input string tag, output logic [7:0] out);
    @(negedge clk);
    bus.uio_in = cmd;
    bus.ui_in  = data;
    #1;
    out = bus.uo_out;
    check_eq(tag, out, data ^ m_ks);
    @(posedge clk);
    model_apply(cmd);
  endtask

  // Seed 1 clk, run 1 clk, then each byte held 8 clks; sample on the last clk of each byte.
  task automatic run_stream(input logic [7:0] seed, input logic [7:0] din [4],
                            output logic [7:0] dout [4]);
    logic [7:0] o;
    do_cycle(seed, 8'h00, "stream_seed", o);
    do_cycle(8'h00, 8'h00, "stream_run", o);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        do_cycle(8'h00, din[b], "stream_data", o);
        if (k == 7) dout[b] = o;
      end
    end
  endtask

  task automatic clear_gap();
    logic [7:0] o;
    do_cycle(8'hFF, 8'h11, "gap_clear", o);
    do_cycle(8'h00, 8'h22, "gap_run0", o);
    do_cycle(8'h00, 8'h33, "gap_run1", o);
  endtask

  initial begin
    logic [7:0] pt [4];
    logic [7:0] ct [4];
    logic [7:0] rt [4];
    logic [7:0] ct2 [4];
    logic [7:0] o;
    logic [7:0] cmd;
    logic       differs;
    int         budget;

    pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;

    // Reset state: pass-through, uio tied off.
    rst_n = 1'b0;
    bus.ena = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in = 8'hDE;
    model_clear();
    #3;
    check_eq("reset_uo_out", bus.uo_out, 8'hDE);
    check_eq("reset_uio_oe", bus.uio_oe, 8'h00);
    check_eq("reset_uio_out", bus.uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(8'h00, 8'h77, "idle_unseeded", o);
    check_eq("idle_passthru", o, 8'h77);

    // Round trip with seed 3D.
    run_stream(8'h3D, pt, ct);
    $display("encrypt seed=3D ct=%h %h %h %h", ct[0], ct[1], ct[2], ct[3]);
    clear_gap();
    run_stream(8'h3D, ct, rt);
    for (int b = 0; b < 4; b++) begin
      check_eq("roundtrip_pt", rt[b], pt[b]);
      $display("decrypt byte %0d ct=%h -> %h", b, ct[b], rt[b]);
    end
`ifndef TRIVIUM_WARMUP_EN
    differs = 1'b0;
    for (int b = 0; b < 4; b++) if (ct[b] != pt[b]) differs = 1'b1;
    check_eq("ct_nontrivial", differs, 1'b1);
`endif

    // Seed sensitivity with 3C.
    clear_gap();
    run_stream(8'h3C, pt, ct2);
    $display("encrypt seed=3C ct=%h %h %h %h", ct2[0], ct2[1], ct2[2], ct2[3]);
`ifndef TRIVIUM_WARMUP_EN
    differs = 1'b0;
    for (int b = 0; b < 4; b++) if (ct2[b] != ct[b]) differs = 1'b1;
    check_eq("seed_sensitivity", differs, 1'b1);
`endif

    // Clear mid-stream then pass-through.
    do_cycle(8'hFF, 8'hC3, "clear_cmd", o);
    do_cycle(8'h00, 8'h5A, "clear_after", o);
    check_eq("clear_passthru", o, 8'h5A);
    do_cycle(8'h00, 8'hA5, "clear_after2", o);
    check_eq("clear_passthru2", o, 8'hA5);

    // Async reset mid-stream with a non-zero keystream window.
    do_cycle(8'h3D, 8'h00, "ar_seed", o);
    budget = 0;
    while (m_ks == 8'h00 && budget < 200) begin
      do_cycle(8'h00, $urandom_range(0, 255), "ar_run", o);
      budget++;
    end
    if (m_ks == 8'h00) check_eq("ar_ks_timeout", 8'h00, 8'h01);
    @(negedge clk);
    bus.ui_in = 8'h96;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_uo_out", bus.uo_out, 8'h96);
    model_clear();
    #1;
    rst_n = 1'b1;
    do_cycle(8'h00, 8'h4B, "post_reset", o);
    check_eq("post_reset_passthru", o, 8'h4B);

    // Randomized command traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       cmd = 8'hFF;
      else if (r < 12) cmd = 8'($urandom_range(1, 254));
      else             cmd = 8'h00;
      do_cycle(cmd, 8'($urandom_range(0, 255)), "random", o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
